// File: rtl/manch_demod_if.sv
// Frame-layer bundle for the Manchester demodulator; MANCH_PARITY_CHK_EN widens out_rem
// and adds out_par_err.
interface manch_demod_if;
`ifdef MANCH_PARITY_CHK_EN
  localparam int REM_W = 4;
`else
  localparam int REM_W = 3;
`endif

  logic             in_enable;
  logic             in_data;
  logic             out_bit;
  logic             out_bit_valid;
  logic [7:0]       out_byte;
  logic             out_byte_valid;
  logic             out_sof;
  logic             out_eof;
  logic [REM_W-1:0] out_rem;
  logic             out_err;
  logic             out_busy;
`ifdef MANCH_PARITY_CHK_EN
  logic             out_par_err;
`endif

  // Valid/ready: there is no ready. Every qualifier (out_bit_valid, out_byte_valid,
  // out_sof, out_eof, out_err) is a one-clk pulse and the consumer must take its data
  // in that cycle; out_byte holds its value between out_byte_valid pulses.
  modport master (
    input  in_enable, in_data,
    output out_bit, out_bit_valid, out_byte, out_byte_valid,
    output out_sof, out_eof, out_rem, out_err,
`ifdef MANCH_PARITY_CHK_EN
    output out_par_err,
`endif
    output out_busy
  );

  modport slave (
    output in_enable, in_data,
    input  out_bit, out_bit_valid, out_byte, out_byte_valid,
    input  out_sof, out_eof, out_rem, out_err,
`ifdef MANCH_PARITY_CHK_EN
    input  out_par_err,
`endif
    input  out_busy
  );
endinterface

// File: rtl/manch_demod.sv
// ISO 14443-A 106 kb/s subcarrier Manchester demodulator: half-ETU edge counting, SOF/EOF
// detection and LSB-first byte assembly. MANCH_PARITY_CHK_EN enables per-byte odd parity.
module manch_demod #(
  parameter int HALF_ETU = 64,
  parameter int EDGE_THR = 2,
  parameter int CNT_W    = 7
) (
  input  logic          clk,
  input  logic          in_rst_n,
  manch_demod_if.master bif,
  output logic [1:0]    state_dbg
);

`ifdef MANCH_PARITY_CHK_EN
  localparam int IDX_W = 4;
  localparam int SR_W  = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
`else
  localparam int IDX_W = 3;
  localparam int SR_W  = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
`endif
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_ETU - 1);
  localparam logic [2:0]       THR       = 3'(EDGE_THR);

  typedef enum logic [1:0] {HUNT = 2'd0, SOF = 2'd1, DATA = 2'd2} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] half_cnt;
  logic [2:0]       edge_cnt;
  logic             phase;
  logic             h1;
  logic [IDX_W-1:0] bit_idx;
  logic [SR_W-1:0]  sr;
  logic             bit_r, bit_valid_r, byte_valid_r, sof_r, eof_r, err_r;
  logic [7:0]       byte_r;
  logic [IDX_W-1:0] rem_r;
`ifdef MANCH_PARITY_CHK_EN
  logic             par_err_r;
`endif

  logic rise, half_last, act;
  assign rise      = s2 & ~s3;
  assign half_last = (half_cnt == HALF_LAST);
  assign act       = (edge_cnt >= THR);

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state        <= HUNT;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      half_cnt     <= '0;
      edge_cnt     <= '0;
      phase        <= 1'b0;
      h1           <= 1'b0;
      bit_idx      <= '0;
      sr           <= '0;
      bit_r        <= 1'b0;
      bit_valid_r  <= 1'b0;
      byte_r       <= '0;
      byte_valid_r <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      rem_r        <= '0;
      err_r        <= 1'b0;
`ifdef MANCH_PARITY_CHK_EN
      par_err_r    <= 1'b0;
`endif
    end else begin
      s1           <= bif.in_data;
      s2           <= s1;
      s3           <= s2;
      bit_valid_r  <= 1'b0;
      byte_valid_r <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      err_r        <= 1'b0;
`ifdef MANCH_PARITY_CHK_EN
      par_err_r    <= 1'b0;
`endif
      if (!bif.in_enable || state == HUNT) begin
        state    <= HUNT;
        half_cnt <= '0;
        edge_cnt <= '0;
        phase    <= 1'b0;
        h1       <= 1'b0;
        bit_idx  <= '0;
        sr       <= '0;
        // The first rise fixes the window phase for the whole frame.
        if (bif.in_enable && rise) begin
          state    <= SOF;
          half_cnt <= CNT_W'(1);
          edge_cnt <= 3'd1;
        end
      end else if (!half_last) begin
        half_cnt <= half_cnt + CNT_W'(1);
        if (rise && edge_cnt != 3'd7) edge_cnt <= edge_cnt + 3'd1;
      end else begin
        half_cnt <= '0;
        edge_cnt <= {2'b00, rise};
        phase    <= ~phase;
        if (!phase) begin
          h1 <= act;
        end else if (state == SOF) begin
          if (h1 && !act) begin
            sof_r <= 1'b1;
            state <= DATA;
          end else begin
            err_r <= 1'b1;
            state <= HUNT;
          end
        end else if (h1 == act) begin
          // (0,0) closes the frame, (1,1) is a coding violation; both drop the partial byte.
          eof_r <= ~h1;
          err_r <= h1;
          rem_r <= bit_idx;
          state <= HUNT;
        end else begin
          bit_r       <= h1;
          bit_valid_r <= 1'b1;
          if (bit_idx == LAST_IDX) begin
            bit_idx      <= '0;
            byte_valid_r <= 1'b1;
`ifdef MANCH_PARITY_CHK_EN
            byte_r       <= sr;
            par_err_r    <= ~(^sr ^ h1);
`else
            byte_r       <= {h1, sr};
`endif
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
            sr      <= {h1, sr[SR_W-1:1]};
          end
        end
      end
    end
  end

  assign bif.out_bit        = bit_r;
  assign bif.out_bit_valid  = bit_valid_r;
  assign bif.out_byte       = byte_r;
  assign bif.out_byte_valid = byte_valid_r;
  assign bif.out_sof        = sof_r;
  assign bif.out_eof        = eof_r;
  assign bif.out_rem        = rem_r;
  assign bif.out_err        = err_r;
  assign bif.out_busy       = (state == SOF) || (state == DATA);
`ifdef MANCH_PARITY_CHK_EN
  assign bif.out_par_err    = par_err_r;
`endif
  assign state_dbg          = state;

endmodule
